// File: rtl/param_interval_timer.sv
// param_interval_timer
//   Avalon-MM slave interval timer with a parametrised counter width.
//   A down-counter reloads from a software-writable period on terminal count,
//   raising a timeout flag (TO) and a level interrupt when enabled (ITO).
//   Supports one-shot and continuous modes, start/stop control and a
//   coherent multi-word snapshot of the running counter.
//
// Ports
//   clk         system clock
//   reset_n     synchronous active-low reset
//   address     word address (4 bits)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   16-bit write data
//   readdata    16-bit registered read data, valid the cycle after address
//   irq         level interrupt, TO & ITO, driven only from flops
//
// Register map (NW = COUNTER_WIDTH/16)
//   0                  status   : {14'b0, RUN, TO}; any write clears TO
//   1                  control  : {12'b0, 2'b0, CONT, ITO}; wd[2]=START wd[3]=STOP
//   2 .. 2+NW-1        period   : 16-bit slices, LSW first
//   2+NW .. 2+2NW-1    snapshot : any write captures the whole counter
//
// Run-state FSM
//   state   | meaning
//   --------+----------------------------------------------------
//   ST_STOP | counter holds (only a period write reloads it)
//   ST_RUN  | counter decrements; reload + timeout at zero

module param_interval_timer #(
   parameter int          COUNTER_WIDTH = 32,
   parameter logic [63:0] RESET_PERIOD  = 64'd49999,
   parameter bit          ALWAYS_RUN    = 1'b0,
   parameter bit          FIXED_PERIOD  = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq
);

   localparam int NW       = COUNTER_WIDTH / 16;
   localparam int PER_BASE = 2;
   localparam int SNP_BASE = PER_BASE + NW;

   localparam logic [COUNTER_WIDTH-1:0] PERIOD_INIT = RESET_PERIOD[COUNTER_WIDTH-1:0];
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE     = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                     state;
   logic [COUNTER_WIDTH-1:0]   period;
   logic [COUNTER_WIDTH-1:0]   counter;
   logic [COUNTER_WIDTH-1:0]   snapshot;
   logic                       to_flag;
   logic                       ito;
   logic                       cont;
   logic                       force_reload;

   logic                       wr_en;
   logic                       sts_wr;
   logic                       ctl_wr;
   logic                       snp_wr;
   logic                       per_wr;
   logic [NW-1:0]              per_sel;
   logic [15:0]                rd_mux;
   logic                       run;
   logic                       cont_eff;
   logic                       timeout_event;

   assign wr_en    = chipselect & ~write_n;
   assign run      = (state == ST_RUN);
   assign cont_eff = ALWAYS_RUN | cont;

   // A reload cycle is never a timeout cycle, even when the counter sits at 0.
   assign timeout_event = run && !force_reload && (counter == '0);

   always_comb begin
      sts_wr  = wr_en && (address == 4'd0);
      ctl_wr  = wr_en && (address == 4'd1);
      per_sel = '0;
      snp_wr  = 1'b0;
      for (int i = 0; i < NW; i++) begin
         per_sel[i] = wr_en && (address == 4'(PER_BASE + i)) && !FIXED_PERIOD;
         if (wr_en && (address == 4'(SNP_BASE + i))) begin
            snp_wr = 1'b1;
         end
      end
      per_wr = |per_sel;
   end

   always_comb begin
      rd_mux = '0;
      if (address == 4'd0) begin
         rd_mux = {14'b0, run, to_flag};
      end else if (address == 4'd1) begin
         rd_mux = {12'b0, 2'b0, cont, ito};
      end
      for (int i = 0; i < NW; i++) begin
         if (address == 4'(PER_BASE + i)) begin
            rd_mux = period[16*i +: 16];
         end
         if (address == 4'(SNP_BASE + i)) begin
            rd_mux = snapshot[16*i +: 16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ALWAYS_RUN ? ST_RUN : ST_STOP;
         period       <= PERIOD_INIT;
         counter      <= PERIOD_INIT;
         snapshot     <= '0;
         to_flag      <= 1'b0;
         ito          <= 1'b0;
         cont         <= 1'b0;
         force_reload <= 1'b0;
         readdata     <= '0;
      end else begin
         readdata     <= rd_mux;
         force_reload <= per_wr;

         for (int i = 0; i < NW; i++) begin
            if (per_sel[i]) begin
               period[16*i +: 16] <= writedata;
            end
         end

         // The reload in the force cycle sees the period already updated by
         // the write one edge earlier.
         if (force_reload || timeout_event) begin
            counter <= period;
         end else if (run) begin
            counter <= counter - CNT_ONE;
         end

         if (snp_wr) begin
            snapshot <= counter;
         end

         // Set beats clear when a timeout and a status write coincide.
         if (timeout_event) begin
            to_flag <= 1'b1;
         end else if (sts_wr) begin
            to_flag <= 1'b0;
         end

         if (ctl_wr) begin
            ito  <= writedata[0];
            cont <= writedata[1];
         end

         if (!ALWAYS_RUN) begin
            case (state)
               ST_STOP: begin
                  if (ctl_wr && writedata[2] && !writedata[3]) begin
                     state <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (ctl_wr && writedata[3]) begin
                     state <= ST_STOP;
                  end else if (timeout_event && !cont_eff) begin
                     state <= ST_STOP;
                  end
               end
               default: state <= ST_STOP;
            endcase
         end
      end
   end

   assign irq = to_flag & ito;

endmodule

// File: tb/tb_param_interval_timer.sv
module tb_param_interval_timer;

   logic              clk;
   logic              reset_n;
   logic [3:0]        address;
   logic [3:0]        cs;
   logic              write_n;
   logic [15:0]       writedata;
   logic [3:0][15:0]  rdata;
   logic [3:0]        irq_v;

   int n_checks = 0;
   int n_errors = 0;

   // 0: default 32-bit, 1: 64-bit, 2: fixed period, 3: 16-bit always-run
   param_interval_timer u_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
      .write_n(write_n), .writedata(writedata), .readdata(rdata[0]), .irq(irq_v[0]));

   param_interval_timer #(.COUNTER_WIDTH(64)) u_b (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
      .write_n(write_n), .writedata(writedata), .readdata(rdata[1]), .irq(irq_v[1]));

   param_interval_timer #(.FIXED_PERIOD(1'b1), .RESET_PERIOD(64'h2000)) u_c (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
      .write_n(write_n), .writedata(writedata), .readdata(rdata[2]), .irq(irq_v[2]));

   param_interval_timer #(.COUNTER_WIDTH(16), .RESET_PERIOD(64'd7), .ALWAYS_RUN(1'b1)) u_d (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]),
      .write_n(write_n), .writedata(writedata), .readdata(rdata[3]), .irq(irq_v[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every bus operation occupies exactly one rising edge.
   task automatic bus_wr(input int dut, input logic [3:0] a, input logic [15:0] d);
      address   = a;
      writedata = d;
      write_n   = 1'b0;
      cs        = 4'(1 << dut);
      @(negedge clk);
      cs        = 4'b0;
      write_n   = 1'b1;
   endtask

   task automatic bus_rd(input int dut, input logic [3:0] a, output logic [15:0] d);
      address = a;
      write_n = 1'b1;
      cs      = 4'(1 << dut);
      @(negedge clk);
      d       = rdata[dut];
      cs      = 4'b0;
   endtask

   // Reference model: timer started with counter == p, after n running edges.
   function automatic longint unsigned n_timeouts(longint unsigned p, bit c, longint unsigned n);
      if (c) return n / (p + 1);
      return (n >= p + 1) ? 64'd1 : 64'd0;
   endfunction

   function automatic longint unsigned cnt_after(longint unsigned p, bit c, longint unsigned n);
      if (!c && n >= p + 1) return p;
      return p - (n % (p + 1));
   endfunction

   function automatic bit run_after(longint unsigned p, bit c, longint unsigned n);
      return c || (n < p + 1);
   endfunction

   initial begin
      logic [15:0]     rv;
      int unsigned     p, k, a;
      bit              c, ie;
      longint unsigned bp, run_edges, exp64;
      int unsigned     wa;

      reset_n   = 1'b0;
      cs        = 4'b0;
      write_n   = 1'b1;
      address   = 4'd0;
      writedata = 16'd0;
      idle(3);
      for (int d = 0; d < 4; d++) begin
         check("rst_readdata", rdata[d], 16'h0000);
         check("rst_irq", irq_v[d], 1'b0);
      end
      reset_n = 1'b1;

      // Always-run 16-bit instance: counts from the first edge after reset.
      idle(5);
      bus_wr(3, 4'd3, 16'h0);
      bus_rd(3, 4'd3, rv); check("ar_snap1", rv, 16'd2);
      bus_rd(3, 4'd0, rv); check("ar_status1", rv, 16'h0002);
      bus_wr(3, 4'd1, 16'h0009);
      check("ar_irq", irq_v[3], 1'b1);
      bus_rd(3, 4'd0, rv); check("ar_status2", rv, 16'h0003);
      bus_wr(3, 4'd3, 16'h0);
      bus_rd(3, 4'd3, rv); check("ar_snap2", rv, 16'd5);

      // Reset defaults of the 32-bit instance.
      bus_rd(0, 4'd0, rv); check("def_status", rv, 16'h0000);
      bus_rd(0, 4'd1, rv); check("def_control", rv, 16'h0000);
      bus_rd(0, 4'd2, rv); check("def_per_lo", rv, 16'hC34F);
      bus_rd(0, 4'd3, rv); check("def_per_hi", rv, 16'h0000);
      bus_rd(0, 4'd7, rv); check("def_unmapped", rv, 16'h0000);
      bus_wr(0, 4'd4, 16'h0);
      bus_rd(0, 4'd4, rv); check("def_snap_lo", rv, 16'hC34F);
      bus_rd(0, 4'd5, rv); check("def_snap_hi", rv, 16'h0000);
      check("def_irq", irq_v[0], 1'b0);

      // Continuous, period 9, interrupt enabled.
      bus_wr(0, 4'd2, 16'd9);
      bus_wr(0, 4'd3, 16'd0);
      bus_wr(0, 4'd0, 16'd0);
      idle(1);
      bus_wr(0, 4'd1, 16'h0007);
      for (int j = 1; j <= 12; j++) begin
         idle(1);
         check("cont_irq", irq_v[0], j >= 10);
      end
      bus_wr(0, 4'd0, 16'd0);
      check("irq_clear", irq_v[0], 1'b0);
      for (int j = 14; j <= 21; j++) begin
         idle(1);
         check("irq_retick", irq_v[0], j >= 20);
      end
      idle(8);
      bus_wr(0, 4'd0, 16'd0);
      check("to_set_wins", irq_v[0], 1'b1);
      bus_wr(0, 4'd1, 16'h000F);
      bus_rd(0, 4'd0, rv); check("start_stop_run", rv, 16'h0001);
      bus_wr(0, 4'd1, 16'h000C);
      bus_rd(0, 4'd0, rv); check("start_stop_idle", rv, 16'h0001);
      check("ito_off_irq", irq_v[0], 1'b0);

      // One-shot, period 4.
      bus_wr(0, 4'd2, 16'd4);
      bus_wr(0, 4'd3, 16'd0);
      bus_wr(0, 4'd0, 16'd0);
      idle(1);
      bus_wr(0, 4'd1, 16'h0005);
      idle(7);
      bus_rd(0, 4'd0, rv); check("oneshot_status", rv, 16'h0001);
      check("oneshot_irq", irq_v[0], 1'b1);
      bus_wr(0, 4'd4, 16'h0);
      bus_rd(0, 4'd4, rv); check("oneshot_hold", rv, 16'd4);
      idle(10);
      bus_wr(0, 4'd0, 16'd0);
      idle(10);
      bus_rd(0, 4'd0, rv); check("oneshot_single", rv, 16'h0000);

      // Randomised period / mode / run length against the model.
      for (int it = 0; it < 20; it++) begin
         p  = $urandom_range(0, 12);
         c  = 1'($urandom_range(0, 1));
         ie = 1'($urandom_range(0, 1));
         k  = $urandom_range(0, 40);
         bus_wr(0, 4'd1, 16'h0008);
         bus_wr(0, 4'd2, 16'(p));
         bus_wr(0, 4'd3, 16'd0);
         bus_wr(0, 4'd0, 16'd0);
         idle(1);
         bus_wr(0, 4'd1, {12'b0, 2'b01, c, ie});
         idle(int'(k));
         bus_wr(0, 4'd4, 16'h0);
         bus_rd(0, 4'd0, rv);
         check("rnd_status", rv, {14'b0, run_after(p, c, k + 1), n_timeouts(p, c, k + 1) != 0});
         check("rnd_irq", irq_v[0], ie && (n_timeouts(p, c, k + 2) != 0));
         bus_rd(0, 4'd4, rv);
         check("rnd_snap_lo", rv, cnt_after(p, c, k) & 64'hFFFF);
         bus_rd(0, 4'd5, rv);
         check("rnd_snap_hi", rv, 16'h0000);
      end

      // Period write mid-count: counter 0x1234 at the write edge.
      bus_wr(0, 4'd1, 16'h0008);
      bus_wr(0, 4'd2, 16'h2000);
      bus_wr(0, 4'd3, 16'h0000);
      bus_wr(0, 4'd0, 16'd0);
      idle(1);
      bus_wr(0, 4'd1, 16'h0006);
      idle(3532);
      bus_wr(0, 4'd4, 16'h0);
      bus_rd(0, 4'd4, rv); check("mid_count_pre", rv, 16'h1234);
      bus_wr(0, 4'd2, 16'h0100);
      idle(1);
      bus_wr(0, 4'd4, 16'h0);
      bus_rd(0, 4'd4, rv); check("mid_reload", rv, 16'h0100);
      bus_rd(0, 4'd0, rv); check("mid_no_to", rv, 16'h0002);

      // 64-bit coherent snapshot.
      bp = 64'h0001_0000_0000_0005;
      bus_wr(1, 4'd2, 16'h0005);
      bus_wr(1, 4'd3, 16'h0000);
      bus_wr(1, 4'd4, 16'h0000);
      bus_wr(1, 4'd5, 16'h0001);
      bus_wr(1, 4'd0, 16'h0000);
      idle(1);
      bus_wr(1, 4'd1, 16'h0006);
      run_edges = 0;
      for (int it = 0; it < 3; it++) begin
         k = $urandom_range(0, 40);
         idle(int'(k));
         run_edges += k;
         wa = $urandom_range(6, 9);
         bus_wr(1, 4'(wa), 16'h0);
         exp64 = bp - run_edges;
         run_edges += 5;
         for (int w = 0; w < 4; w++) begin
            bus_rd(1, 4'(6 + w), rv);
            check("snap64_word", rv, (exp64 >> (16 * w)) & 64'hFFFF);
         end
      end
      bus_rd(1, 4'd5, rv); check("per64_w3", rv, 16'h0001);

      // Fixed period: writes neither update nor reload.
      bus_wr(2, 4'd1, 16'h0006);
      a = $urandom_range(0, 20);
      idle(int'(a));
      bus_wr(2, 4'd2, 16'h0100);
      bus_wr(2, 4'd4, 16'h0);
      bus_rd(2, 4'd4, rv); check("fixed_counter", rv, 16'(32'h2000 - (a + 1)));
      bus_rd(2, 4'd2, rv); check("fixed_period", rv, 16'h2000);
      bus_rd(2, 4'd0, rv); check("fixed_status", rv, 16'h0002);

      // Reset with a reload pending.
      bus_wr(0, 4'd2, 16'h0055);
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      bus_rd(0, 4'd2, rv); check("rst2_period", rv, 16'hC34F);
      bus_rd(0, 4'd0, rv); check("rst2_status", rv, 16'h0000);
      check("rst2_irq", irq_v[0], 1'b0);
      bus_wr(0, 4'd4, 16'h0);
      bus_rd(0, 4'd4, rv); check("rst2_counter", rv, 16'hC34F);
      bus_rd(0, 4'd1, rv); check("rst2_control", rv, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/param_interval_timer.md
Name: param_interval_timer

Overview:
- Avalon-MM slave interval timer with a parametrised counter width.
- Adds a software-writable period, start/stop control, and one-shot vs continuous mode.
- Adds a multi-word snapshot.
- Provides the system tick or timeout IRQ to the Nios II processor. Its default parameters give the same register map as the current 32-bit-snap system clock timer.

Parameters:
COUNTER_WIDTH, 32, counter/period/snapshot width in bits; one of 16, 32, 48, 64. NW = COUNTER_WIDTH/16.
RESET_PERIOD, 49999, period register reset value (countdown start, in clk cycles minus 1).
ALWAYS_RUN, 0, if 1: counter runs from reset; START/STOP and CONT are ignored and mode is forced continuous.
FIXED_PERIOD, 0, if 1: period writes are ignored (no update, no reload).

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
address  in  4  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq  out  1  interrupt request, level

Behaviour:
- Reset (sampled on the clk edge while reset_n=0):
  - period=RESET_PERIOD, counter=RESET_PERIOD, snapshot=0.
  - TO=0, RUN=ALWAYS_RUN, control=0, readdata=0, irq=0.
- Register map (wr = chipselect & ~write_n):
  - 0 status: read {14'b0, RUN, TO}. Any write clears TO.
  - 1 control: read {12'b0, 0, 0, CONT, ITO}. Write stores ITO=wd[0] and CONT=wd[1].
    - wd[2]=START: RUN<=1.
    - wd[3]=STOP: RUN<=0.
    - STOP wins if both are set. START while already running has no other effect (no reload).
  - 2 .. 2+NW-1 period words, LSW first: read/write the 16-bit slice.
  - 2+NW .. 2+2NW-1 snapshot words, LSW first.
    - Any write to any snapshot word copies the full counter into the snapshot in one cycle (coherent multi-word read).
    - Reads return the stored slice.
  - Other addresses: read 0, writes ignored.
- Read latency: readdata is registered from the address mux every cycle; data is valid the cycle after the address is presented.
- force_reload: a 1-cycle pulse registered from any period word write (unless FIXED_PERIOD).
  - In the next cycle the counter loads the already-updated period, regardless of RUN.
- Counter priority per cycle:
  - force_reload → counter<=period.
  - else RUN & counter==0 → counter<=period; timeout_event=1.
  - else RUN → counter<=counter-1.
  - else hold.
- Mode:
  - On timeout_event with CONT=0 (and ALWAYS_RUN=0), RUN<=0 in the same edge as the reload. The counter is left at period.
  - With CONT=1, counting continues.
- Tick period = period+1 cycles.
- period=0 while running gives a timeout_event every cycle.
- TO:
  - Set on timeout_event.
  - Cleared by a status write.
  - A timeout_event in the same cycle as a status write → TO=1 (set wins).
- irq = TO & ITO, driven from registers (no combinational path from bus inputs).
- A force_reload cycle never produces a timeout_event even if counter==0.
- Counter arithmetic is unsigned modulo 2^COUNTER_WIDTH. Decrement never occurs from 0, so there is no wrap.
- A synchronous reset mid-count returns all state to reset values at the next edge; pending force_reload is discarded.

Test Plan:
1. Reset defaults (COUNTER_WIDTH=32, ALWAYS_RUN=0) → readdata=0; read addr 0 → 0x0000; read addr 2 → 0xC34F, addr 3 → 0x0000; irq=0; counter static.
2. Write period=9 (addr2=9, addr3=0), control=0x0007 (ITO, CONT, START) → TO sets every 10 cycles; irq high after the first expiry; status write clears irq the next cycle; the next tick re-asserts it.
3. One-shot: period=4, control=0x0005 → exactly one timeout_event 5 cycles after START; read addr 0 → 0x0001 (RUN=0, TO=1); counter holds 4.
4. Snapshot at COUNTER_WIDTH=64: period=0x0001_0000_0000_0005, run; write addr 6 → reads of addr 6..9 return one coherent 64-bit value equal to the counter at the write edge.
5. Simultaneous events: a status write on the exact cycle the counter hits 0 → TO stays 1. START|STOP (0x000C) → RUN=0.
6. Period write while running mid-count (counter=0x1234) → counter=new period 2 cycles after the write; no spurious TO. With FIXED_PERIOD=1, the same write → period and counter unchanged.
